// File: rtl/multi_lane_serializer.sv
// -----------------------------------------------------------------------------
// multi_lane_serializer
//
// Accepts words through a valid/ready handshake into a small FIFO and shifts
// them out on LANES parallel serial lines. Words follow each other with no idle
// cycle while the FIFO has data. sync_out marks the last bit of every
// SYNC_EVERY-th word so the receiver can frame the stream.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_data holds a word
//   in_data   in   WORD_W*LANES bits; lane i = in_data[i*WORD_W +: WORD_W]
//   in_ready  out  FIFO can accept a word (low while in reset)
//   data_out  out  registered serial bit per lane
//   clk_en    out  registered; high while a valid bit is on data_out
//   sync_out  out  registered; high on the last bit of every SYNC_EVERY-th word
//   busy      out  FIFO non-empty or a word is being shifted
// -----------------------------------------------------------------------------
module multi_lane_serializer #(
    parameter int WORD_W     = 8,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int SYNC_EVERY = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [WORD_W*LANES-1:0]   in_data,
    output logic                      in_ready,
    output logic [LANES-1:0]          data_out,
    output logic                      clk_en,
    output logic                      sync_out,
    output logic                      busy
);

    localparam int DW    = WORD_W * LANES;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(WORD_W);
    localparam int WC_W  = (SYNC_EVERY > 1) ? $clog2(SYNC_EVERY) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [WC_W-1:0]  WC_WRAP  = WC_W'(SYNC_EVERY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;
    logic [DW-1:0]    head;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    // Gated with rst_n so no word can be taken while the block is held in reset.
    assign in_ready = !full && rst_n;
    assign push     = in_valid && in_ready;
    assign head     = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-lane bit selection: first bit of the FIFO head word and of the
    // shift register, plus the remaining bits after that one is taken.
    // ------------------------------------------------------------------
    logic [DW-1:0]    sr_q, sr_d;
    logic [LANES-1:0] head_bits, cur_bits;
    logic [DW-1:0]    head_rest, cur_rest;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WORD_W-1:0] head_word;
        logic [WORD_W-1:0] cur_word;

        assign head_word = head[gi*WORD_W +: WORD_W];
        assign cur_word  = sr_q[gi*WORD_W +: WORD_W];

        if (MSB_FIRST) begin : g_msb
            assign head_bits[gi] = head_word[WORD_W-1];
            assign cur_bits[gi]  = cur_word[WORD_W-1];
            assign head_rest[gi*WORD_W +: WORD_W] = {head_word[WORD_W-2:0], 1'b0};
            assign cur_rest[gi*WORD_W +: WORD_W]  = {cur_word[WORD_W-2:0], 1'b0};
        end else begin : g_lsb
            assign head_bits[gi] = head_word[0];
            assign cur_bits[gi]  = cur_word[0];
            assign head_rest[gi*WORD_W +: WORD_W] = {1'b0, head_word[WORD_W-1:1]};
            assign cur_rest[gi*WORD_W +: WORD_W]  = {1'b0, cur_word[WORD_W-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Shift FSM
    // bit_cnt_q counts the bits still to come after the one on data_out,
    // so bit_cnt_q == 0 means the last bit of the word is being shown.
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic [LANES-1:0] data_out_q, data_out_d;
    logic             clk_en_q, clk_en_d;
    logic             sync_out_q, sync_out_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        sr_d       = sr_q;
        data_out_d = '0;
        clk_en_d   = 1'b0;
        sync_out_d = 1'b0;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    sr_d       = head_rest;
                    data_out_d = head_bits;
                    clk_en_d   = 1'b1;
                    bit_cnt_d  = BIT_LAST;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    data_out_d = cur_bits;
                    sr_d       = cur_rest;
                    clk_en_d   = 1'b1;
                    bit_cnt_d  = bit_cnt_q - BIT_W'(1);
                    // The bit driven on this edge is the word's last one.
                    if (bit_cnt_q == BIT_W'(1)) begin
                        if (word_cnt_q == WC_WRAP) begin
                            word_cnt_d = '0;
                            sync_out_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                        end
                    end
                end else if (!empty) begin
                    // Chain the next word onto the same edge: no gap cycle.
                    pop        = 1'b1;
                    sr_d       = head_rest;
                    data_out_d = head_bits;
                    clk_en_d   = 1'b1;
                    bit_cnt_d  = BIT_LAST;
                end else begin
                    bit_cnt_d = BIT_LAST;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= BIT_LAST;
            word_cnt_q <= '0;
            sr_q       <= '0;
            data_out_q <= '0;
            clk_en_q   <= 1'b0;
            sync_out_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            sr_q       <= sr_d;
            data_out_q <= data_out_d;
            clk_en_q   <= clk_en_d;
            sync_out_q <= sync_out_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign data_out = data_out_q;
    assign clk_en   = clk_en_q;
    assign sync_out = sync_out_q;
    assign busy     = (state_q == SHIFT) || !empty;

endmodule

// File: tb/tb_multi_lane_serializer.sv
// -----------------------------------------------------------------------------
// tb_multi_lane_serializer
//
// Two instances share one input stream:
//   dut0: 2 lanes, MSB first, sync every 4 words
//   dut1: 2 lanes, LSB first, sync every word
// The driver records every accepted word (data, word number since reset,
// accept cycle) in a scoreboard queue. A monitor on the falling edge walks
// that queue per instance and checks every output cycle against bits computed
// directly from the word value and its position in the stream.
// -----------------------------------------------------------------------------
module tb_multi_lane_serializer;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int D  = 4;
    localparam int DW = W * L;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic [L-1:0]  dout0, dout1;
    logic          ce0, ce1, sy0, sy1, bz0, bz1, rdy0, rdy1;

    multi_lane_serializer #(
        .WORD_W(W), .LANES(L), .FIFO_DEPTH(D), .SYNC_EVERY(4), .MSB_FIRST(1'b1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .data_out(dout0), .clk_en(ce0), .sync_out(sy0), .busy(bz0)
    );

    multi_lane_serializer #(
        .WORD_W(W), .LANES(L), .FIFO_DEPTH(D), .SYNC_EVERY(1), .MSB_FIRST(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .data_out(dout1), .clk_en(ce1), .sync_out(sy1), .busy(bz1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            idx;   // word number since the last reset
        int            acc;   // cycle of the accepting edge
    } item_t;

    item_t exp_words[$];
    int    rd_idx[2];
    int    bit_pos[2];
    int    cyc = 0;
    int    word_idx = 0;
    int    errors = 0;
    int    checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, k, $time, act, exp);
        end
    endtask

    // Bit at stream position pos (0 = first sent) of every lane.
    function automatic logic [L-1:0] exp_bits(input logic [DW-1:0] d, input int pos,
                                              input bit msb);
        logic [L-1:0] r;
        for (int l = 0; l < L; l++) begin
            r[l] = msb ? d[l*W + (W-1-pos)] : d[l*W + pos];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        logic [L-1:0] d;
        logic         ce, sy, bz, rd;
        int           pend, fifo_n;
        bit           sync_exp;
        item_t        it;
        for (int k = 0; k < 2; k++) begin
            d  = (k == 0) ? dout0 : dout1;
            ce = (k == 0) ? ce0 : ce1;
            sy = (k == 0) ? sy0 : sy1;
            bz = (k == 0) ? bz0 : bz1;
            rd = (k == 0) ? rdy0 : rdy1;
            if (!rst_n) begin
                check("reset_outputs", k, {26'd0, d, ce, sy, bz, rd}, 32'd0);
                rd_idx[k]  = exp_words.size();
                bit_pos[k] = 0;
            end else begin
                pend = exp_words.size() - rd_idx[k];
                check("busy", k, {31'd0, bz}, (pend != 0) ? 32'd1 : 32'd0);
                fifo_n = pend - (ce ? 1 : 0);
                check("in_ready", k, {31'd0, rd}, (fifo_n < D) ? 32'd1 : 32'd0);
                if (ce) begin
                    if (pend == 0) begin
                        check("spurious_clk_en", k, {31'd0, ce}, 32'd0);
                    end else begin
                        it = exp_words[rd_idx[k]];
                        if (bit_pos[k] == 0) begin
                            check("first_bit_latency", k, (cyc >= it.acc + 1) ? 32'd1 : 32'd0, 32'd1);
                        end
                        check("data_out", k, {30'd0, d}, {30'd0, exp_bits(it.data, bit_pos[k], k == 0)});
                        sync_exp = (bit_pos[k] == W-1) && ((k == 1) || (it.idx % 4 == 3));
                        check("sync_out", k, {31'd0, sy}, {31'd0, sync_exp});
                        bit_pos[k]++;
                        if (bit_pos[k] == W) begin
                            bit_pos[k] = 0;
                            rd_idx[k]++;
                        end
                    end
                end else begin
                    check("idle_outputs", k, {29'd0, d, sy}, 32'd0);
                    if (bit_pos[k] != 0) begin
                        check("gap_mid_word", k, bit_pos[k], 32'd0);
                    end else if (pend > 0) begin
                        // A pending word may be idle only before its first-bit edge.
                        check("stall", k, (cyc < exp_words[rd_idx[k]].acc + 1) ? 32'd1 : 32'd0, 32'd1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic send_word(input logic [DW-1:0] data);
        bit    done = 1'b0;
        bit    will_accept;
        item_t it;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_data     = data;
            will_accept = rdy0;
            @(posedge clk);
            #1;
            if (will_accept) begin
                it.data = data;
                it.idx  = word_idx;
                it.acc  = cyc;
                exp_words.push_back(it);
                word_idx++;
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 0, {31'd0, done}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (!bz0 && !bz1 && !ce0 && !ce1) done = 1'b1;
        end
        if (!done) check("idle_timeout", 0, {31'd0, done}, 32'd1);
    endtask

    task automatic reset_now();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_reset", 0, {26'd0, dout0, ce0, sy0, bz0, rdy0}, 32'd0);
        check("async_reset", 1, {26'd0, dout1, ce1, sy1, bz1, rdy1}, 32'd0);
        word_idx = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int  tgt;
        bit  found;
        logic [7:0] c;

        #1;
        check("reset_in_ready", 0, {31'd0, rdy0}, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single word: lane0 0xA5 (MSB first on dut0), lane1 0x3C.
        send_word({8'h3C, 8'hA5});
        wait_idle();

        // Multi-lane pattern (LSB first on dut1).
        send_word(16'hF00F);
        wait_idle();

        // Back-to-back from a fresh reset: sync on the 4th word for dut0.
        @(posedge clk);
        reset_now();
        for (int v = 1; v <= 5; v++) begin
            c = 8'(v);
            send_word({c ^ 8'hF0, c});
        end
        wait_idle();

        // Backpressure: valid held high with an incrementing counter.
        for (int i = 0; i < 64; i++) begin
            c = 8'(i);
            send_word({~c, c});
        end
        wait_idle();

        // Random data with random idle gaps.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_word(16'($urandom));
        end
        wait_idle();

        // Reset in the middle of the second of three words.
        tgt = exp_words.size();
        for (int i = 0; i < 3; i++) send_word(16'($urandom));
        idle(1);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(posedge clk);
            if (rd_idx[0] == tgt + 1 && bit_pos[0] == 3) found = 1'b1;
        end
        check("mid_word_reached", 0, {31'd0, found}, 32'd1);
        reset_now();

        // Post-reset stream: clean 0x3C frame, sync on the 4th word.
        send_word({8'h5A, 8'h3C});
        for (int i = 0; i < 4; i++) send_word(16'($urandom));
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
